// File: rtl/alu_decode.sv
// alu_decode: MIPS instruction decode stage feeding alu_top.
// Decodes into instr_ID, buffers in a 2-entry FIFO, counts drops.

package alu_decode_pkg;

  typedef struct packed {
    logic [31:0] ir;
    logic [3:0]  id;
    logic [4:0]  dst;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [31:0] imm;
    logic        use_imm;
  } dec_t;

endpackage

module alu_decode
  import alu_decode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic [31:0]      out_instr_ID,
  output logic [4:0]       out_dst,
  output logic [4:0]       out_src_a,
  output logic [4:0]       out_src_b,
  output logic [31:0]      out_imm,
  output logic             out_use_imm,
  output logic [CNT_W-1:0] illegal_count
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] sh;

  assign op = in_ir[31:26];
  assign rs = in_ir[25:21];
  assign rt = in_ir[20:16];
  assign rd = in_ir[15:11];
  assign sh = in_ir[10:6];
  assign fn = in_ir[5:0];

  logic        r_op;
  logic [3:0]  id;
  logic [31:0] sx_imm;
  logic [31:0] zx_imm;

  assign r_op   = (op == 6'h00);
  assign sx_imm = {{16{in_ir[15]}}, in_ir[15:0]};
  assign zx_imm = {16'h0000, in_ir[15:0]};

  // Map op/fn onto the ALU dispatch code; 0 marks illegal.
  always_comb begin
    id = 4'd0;
    unique case (1'b1)
      r_op && fn == 6'h20: id = 4'd1;
      r_op && fn == 6'h22: id = 4'd2;
      r_op && fn == 6'h21: id = 4'd3;
      r_op && fn == 6'h23: id = 4'd4;
      r_op && fn == 6'h24: id = 4'd7;
      r_op && fn == 6'h25: id = 4'd8;
      r_op && fn == 6'h00: id = 4'd11;
      r_op && fn == 6'h02: id = 4'd12;
      op == 6'h08:         id = 4'd5;
      op == 6'h09:         id = 4'd6;
      op == 6'h0C:         id = 4'd9;
      op == 6'h0D:         id = 4'd10;
      default:             id = 4'd0;
    endcase
  end

  logic is_shift;
  logic is_rtype;
  logic is_isx;
  logic is_izx;
  logic legal;

  assign is_shift = (id == 4'd11) || (id == 4'd12);
  assign is_isx   = (id == 4'd5) || (id == 4'd6);
  assign is_izx   = (id == 4'd9) || (id == 4'd10);
  assign is_rtype = (id == 4'd1) || (id == 4'd2) ||
                    (id == 4'd3) || (id == 4'd4) ||
                    (id == 4'd7) || (id == 4'd8);
  assign legal    = (id != 4'd0);

  dec_t dec;

  // Operand routing per instruction class.
  always_comb begin
    dec    = '0;
    dec.ir = in_ir;
    dec.id = id;
    unique case (1'b1)
      is_shift: begin
        dec.dst     = rd;
        dec.src_a   = rt;
        dec.imm     = {27'b0, sh};
        dec.use_imm = 1'b1;
      end
      is_rtype: begin
        dec.dst   = rd;
        dec.src_a = rs;
        dec.src_b = rt;
      end
      is_isx: begin
        dec.dst     = rt;
        dec.src_a   = rs;
        dec.imm     = sx_imm;
        dec.use_imm = 1'b1;
      end
      is_izx: begin
        dec.dst     = rt;
        dec.src_a   = rs;
        dec.imm     = zx_imm;
        dec.use_imm = 1'b1;
      end
      default: begin
        dec.dst = 5'd0;
      end
    endcase
  end

  dec_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       take;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign take      = in_valid & in_ready;
  assign push      = take & legal;
  assign pop       = out_valid & out_ready;

  // Occupancy and pointers; flush empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; a flushed push never lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Saturating drop counter; survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_count <= '0;
    end else if (take && !legal &&
                 illegal_count != {CNT_W{1'b1}}) begin
      illegal_count <= illegal_count + CNT_W'(1);
    end
  end

  dec_t head;

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_ir       = head.ir;
  assign out_instr_ID = {28'b0, head.id};
  assign out_dst      = head.dst;
  assign out_src_a    = head.src_a;
  assign out_src_b    = head.src_b;
  assign out_imm      = head.imm;
  assign out_use_imm  = head.use_imm;

endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed and randomized checks of alu_decode
// against a queue-based reference model.

module tb_alu_decode;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_ir = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_ir;
  logic [31:0]   out_instr_ID;
  logic [4:0]    out_dst;
  logic [4:0]    out_src_a;
  logic [4:0]    out_src_b;
  logic [31:0]   out_imm;
  logic          out_use_imm;
  logic [CW-1:0] illegal_count;

  alu_decode #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_instr_ID(out_instr_ID),
    .out_dst(out_dst), .out_src_a(out_src_a),
    .out_src_b(out_src_b), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] id;
    logic [4:0]  dst;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] imm;
    logic        ui;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int ill_exp = 0;
  int sat_max = (1 << CW) - 1;

  function automatic ent_t dut_ent();
    ent_t e;
    e = '{out_ir, out_instr_ID, out_dst, out_src_a,
          out_src_b, out_imm, out_use_imm};
    return e;
  endfunction

  // Reference decode straight from the instruction table.
  function automatic ent_t ref_dec(input logic [31:0] ir,
                                   output bit ok);
    ent_t e;
    int op, fn, rs, rt, rd, sh, lo;
    op = int'(ir[31:26]); rs = int'(ir[25:21]);
    rt = int'(ir[20:16]); rd = int'(ir[15:11]);
    sh = int'(ir[10:6]);  fn = int'(ir[5:0]);
    lo = int'(ir[15:0]);
    e = '0; e.ir = ir; ok = 1'b1;
    if (op == 0) begin
      e.dst = 5'(rd);
      case (fn)
        'h20: e.id = 1;  'h22: e.id = 2;
        'h21: e.id = 3;  'h23: e.id = 4;
        'h24: e.id = 7;  'h25: e.id = 8;
        'h00: e.id = 11; 'h02: e.id = 12;
        default: ok = 1'b0;
      endcase
      if (e.id >= 11) begin
        e.a = 5'(rt); e.ui = 1'b1; e.imm = 32'(sh);
      end else begin
        e.a = 5'(rs); e.b = 5'(rt);
      end
    end else begin
      e.dst = 5'(rt); e.a = 5'(rs); e.ui = 1'b1;
      case (op)
        'h08: e.id = 5;  'h09: e.id = 6;
        'h0C: e.id = 9;  'h0D: e.id = 10;
        default: ok = 1'b0;
      endcase
      if (e.id == 5 || e.id == 6)
        e.imm = (lo >= 32768) ? 32'(lo - 65536) : 32'(lo);
      else
        e.imm = 32'(lo);
    end
    if (!ok) e = '0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || illegal_count !== '0) begin
      errors++;
      $display("FAIL reset_assert valid=%b cnt=%0d want 0 0",
               out_valid, illegal_count);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (dut_ent() !== '0 || illegal_count !== '0) begin
      errors++;
      $display("FAIL reset_payload got %h cnt %0d want 0",
               dut_ent(), illegal_count);
    end
  endtask

  task automatic test_add();
    ent_t w;
    w = '{32'h00221820, 32'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0};
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'h00221820;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut_ent() !== w) begin
      errors++;
      $display("FAIL add got v=%b %h want v=1 %h",
               out_valid, dut_ent(), w);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_imm_shift();
    logic [31:0] irs [3];
    ent_t        ws  [3];
    bit ok;
    irs[0] = 32'h2085FFFF;
    ws[0]  = '{32'h2085FFFF, 32'd5, 5'd5, 5'd4, 5'd0,
               32'hFFFFFFFF, 1'b1};
    irs[1] = 32'h30858000;
    ws[1]  = '{32'h30858000, 32'd9, 5'd5, 5'd4, 5'd0,
               32'h00008000, 1'b1};
    irs[2] = 32'h00011100;
    ws[2]  = '{32'h00011100, 32'd11, 5'd2, 5'd1, 5'd0,
               32'd4, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ir = irs[i];
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || dut_ent() !== ws[i]) begin
        errors++;
        $display("FAIL imm_shift%0d got %h want %h",
                 i, dut_ent(), ws[i]);
      end
      checks++;
      if (ref_dec(irs[i], ok) !== ws[i] || !ok) begin
        errors++;
        $display("FAIL model%0d got %h want %h",
                 i, ref_dec(irs[i], ok), ws[i]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] irs [3];
    bit ok;
    irs[0] = 32'h00221820;
    irs[1] = 32'h00221822;
    irs[2] = 32'h00221825;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ir = irs[i];
      checks++;
      if (in_ready !== (i < 2)) begin
        errors++;
        $display("FAIL bp_ready%0d got %b want %b",
                 i, in_ready, i < 2);
      end
      step();
    end
    checks++;
    if (in_ready !== 1'b0 || dut_ent() !== ref_dec(irs[0], ok)) begin
      errors++;
      $display("FAIL bp_hold rdy=%b got %h want %h", in_ready,
               dut_ent(), ref_dec(irs[0], ok));
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || dut_ent() !== ref_dec(irs[1], ok)) begin
      errors++;
      $display("FAIL bp_pop1 rdy=%b got %h want %h", in_ready,
               dut_ent(), ref_dec(irs[1], ok));
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut_ent() !== ref_dec(irs[2], ok)) begin
      errors++;
      $display("FAIL bp_third v=%b got %h want %h", out_valid,
               dut_ent(), ref_dec(irs[2], ok));
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] irs [2];
    irs[0] = 32'hFC000000;
    irs[1] = 32'h0000003F;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_ir = irs[i];
      step();
      in_valid = 1'b0;
      ill_exp++;
      checks++;
      if (out_valid !== 1'b0 || int'(illegal_count) != ill_exp) begin
        errors++;
        $display("FAIL illegal%0d v=%b cnt=%0d want v=0 cnt=%0d",
                 i, out_valid, illegal_count, ill_exp);
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'h00221820; step();
    in_ir = 32'h00221822; step();
    flush = 1'b1; in_ir = 32'h00221825; step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        int'(illegal_count) != ill_exp) begin
      errors++;
      $display("FAIL flush_full v=%b r=%b cnt=%0d want 0 1 %0d",
               out_valid, in_ready, illegal_count, ill_exp);
    end
    in_valid = 1'b1; in_ir = 32'h00221820; step();
    flush = 1'b1; in_ir = 32'h00221822; step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_push valid=%b want 0", out_valid);
    end
    flush = 1'b1; in_valid = 1'b1; in_ir = 32'hFC000000; step();
    flush = 1'b0; in_valid = 1'b0;
    ill_exp++;
    step();
    checks++;
    if (out_valid !== 1'b0 || int'(illegal_count) != ill_exp) begin
      errors++;
      $display("FAIL flush_illegal v=%b cnt=%0d want 0 %0d",
               out_valid, illegal_count, ill_exp);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'h00221820; step();
    in_ir = 32'h00221822; step();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    ill_exp = 0;
    checks++;
    if (out_valid !== 1'b0 || illegal_count !== '0 ||
        in_ready !== 1'b1 || dut_ent() !== '0) begin
      errors++;
      $display("FAIL async_rst v=%b cnt=%0d r=%b p=%h want 0 0 1 0",
               out_valid, illegal_count, in_ready, dut_ent());
    end
    #2 reset = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'h00221825; step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 ||
        dut_ent() !== ref_dec(32'h00221825, ok)) begin
      errors++;
      $display("FAIL async_resume got %h want %h",
               dut_ent(), ref_dec(32'h00221825, ok));
    end
    step();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [5:0] fns [8];
    logic [5:0] ops [4];
    logic [31:0] r;
    int sel;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h21;
    fns[3] = 6'h23; fns[4] = 6'h24; fns[5] = 6'h25;
    fns[6] = 6'h00; fns[7] = 6'h02;
    ops[0] = 6'h08; ops[1] = 6'h09;
    ops[2] = 6'h0C; ops[3] = 6'h0D;
    r = $urandom();
    sel = $urandom_range(0, 9);
    if (sel < 6)
      return {6'h00, r[25:6], fns[$urandom_range(0, 7)]};
    else if (sel < 8)
      return {ops[$urandom_range(0, 3)], r[25:0]};
    else if (sel == 8)
      return {6'h00, r[25:0]};
    return r;
  endfunction

  task automatic test_random();
    ent_t q [$];
    ent_t e;
    ent_t want;
    bit ok, acc, held;
    held = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_ir = rand_ir();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (in_ready !== (q.size() != 2)) begin
        errors++;
        $display("FAIL rnd_ready c%0d got %b want %b",
                 c, in_ready, q.size() != 2);
      end
      want = (q.size() > 0) ? q[0] : '0;
      checks++;
      if (out_valid !== (q.size() > 0) || dut_ent() !== want) begin
        errors++;
        $display("FAIL rnd_out c%0d v=%b %h want v=%b %h", c,
                 out_valid, dut_ent(), q.size() > 0, want);
      end
      checks++;
      if (int'(illegal_count) != ill_exp) begin
        errors++;
        $display("FAIL rnd_cnt c%0d got %0d want %0d",
                 c, illegal_count, ill_exp);
      end
      acc = in_valid && (q.size() != 2);
      held = in_valid && !acc;
      e = ref_dec(in_ir, ok);
      if (acc && !ok && ill_exp < sat_max) ill_exp++;
      if (flush) begin
        q.delete();
      end else begin
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (acc && ok) q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
  endtask

  task automatic test_saturate();
    reset = 1'b0;
    #2 reset = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'hFC000000;
    repeat (sat_max - 1) step();
    checks++;
    if (int'(illegal_count) != sat_max - 1) begin
      errors++;
      $display("FAIL sat_pre got %0d want %0d",
               illegal_count, sat_max - 1);
    end
    repeat (6) step();
    in_valid = 1'b0;
    checks++;
    if (int'(illegal_count) != sat_max || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold got %0d v=%b want %0d 0",
               illegal_count, out_valid, sat_max);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm_shift();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode.md
# alu_decode

Decode stage directly upstream of `alu_top`. It accepts raw 32-bit MIPS instructions over a valid/ready handshake and decodes each one into the `instr_ID` code the ALU dispatches on (1–12). It also extracts the register indices and the extended immediate or shift amount. Decoded entries are held in a 2-deep FIFO so fetch and ALU can stall independently. Unsupported encodings are dropped and counted.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating illegal-instruction counter

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous; discards all buffered entries
- `in_valid`  in  1  `in_ir` holds an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_ir`  in  32  raw instruction
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  ALU consumes head entry
- `out_ir`  out  32  original instruction of head entry
- `out_instr_ID`  out  32  decoded ID, 1–12, zero-extended
- `out_dst`  out  5  destination register
- `out_src_a`  out  5  first source register
- `out_src_b`  out  5  second source register (0 when `out_use_imm`=1)
- `out_imm`  out  32  extended immediate or shift amount
- `out_use_imm`  out  1  operand B is `out_imm`
- `illegal_count`  out  `CNT_W`  dropped-instruction count

## Operation
Instruction fields:
- op = ir[31:26], rs = ir[25:21], rt = ir[20:16], rd = ir[15:11], sh = ir[10:6], fn = ir[5:0]

R-type (op = 0): dst = rd, use_imm = 0, src_a = rs, src_b = rt.
- fn 0x20 → add = 1
- fn 0x22 → sub = 2
- fn 0x21 → addu = 3
- fn 0x23 → subu = 4
- fn 0x24 → and = 7
- fn 0x25 → or = 8

Shifts (op = 0): src_a = rt, src_b = 0, use_imm = 1, imm = {27'b0, sh}, dst = rd.
- fn 0x00 → sll = 11
- fn 0x02 → srl = 12
- `ir` = 0 therefore decodes as sll ID 11, which is legal.

I-type: dst = rt, src_a = rs, src_b = 0, use_imm = 1.
- op 0x08 → addi = 5, imm sign-extended
- op 0x09 → addiu = 6, imm sign-extended
- op 0x0C → andi = 9, imm zero-extended
- op 0x0D → ori = 10, imm zero-extended

Any other op/fn combination is illegal:
- It is not enqueued.
- When in_valid & in_ready, `illegal_count` increments by 1 and saturates at all-ones.

FIFO:
- 2 entries, with wrapping write/read pointers and a 2-bit count.
- Push = in_valid & in_ready & legal.
- Pop = out_valid & out_ready.
- Push and pop in the same cycle leave count unchanged.

Flush:
- Count and both pointers go to 0.
- A same-cycle push is discarded.
- An illegal instruction presented in the same cycle is still counted.
- `illegal_count` is not cleared.

## Timing
- Reset (async assert, sync release): count = 0, pointers = 0, `illegal_count` = 0, `out_valid` = 0.
- All `out_*` payload outputs read as 0 after reset and whenever `out_valid` = 0.
- `in_ready` = (count != 2), derived from registered count only, with no combinational path from `out_ready`.
- Latency: an instruction pushed in cycle N appears on `out_*` with `out_valid` = 1 in cycle N+1, provided the FIFO was empty.
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- Full (count = 2): `in_ready` = 0. A pop that cycle does not allow a push in the same cycle; `in_ready` rises the following cycle.
- Empty: `out_valid` = 0, and `out_ready` is ignored.
- Payload stability: while `out_valid` = 1 and `out_ready` = 0, the head entry is held stable.
- Upstream rule: `in_ir` must be held stable while in_valid & !in_ready.
- Reset asserted mid-operation: all buffered entries are lost immediately, without waiting for a clock edge.

## Test plan
- Reset, then idle: `in_ready` = 1, `out_valid` = 0, `illegal_count` = 0, all payload outputs 0.
- Push 0x00221820 (add $3,$1,$2) with `out_ready` = 1 → next cycle: ID 1, dst 3, src_a 1, src_b 2, use_imm 0, `out_ir` = 0x00221820.
- Immediate and shift decode:
  - Push 0x2085FFFF (addi) → ID 5, dst 5, src_a 4, imm 0xFFFFFFFF.
  - Push 0x30858000 (andi) → ID 9, imm 0x00008000.
  - Push 0x00011100 (sll) → ID 11, dst 2, src_a 1, imm 4.
- Backpressure:
  - With `out_ready` = 0, push 3 instructions back-to-back → `in_ready` drops after 2; the 3rd is held by upstream.
  - Raise `out_ready` → outputs appear in order, one per cycle; the 3rd is accepted one cycle after the first pop.
- Illegal and flush:
  - Push 0xFC000000 → not output, `illegal_count` = 1.
  - Fill the FIFO with 2 entries, then assert `flush` alongside a legal push → next cycle `out_valid` = 0, count 0, `illegal_count` unchanged.
- Async reset mid-stream with 2 entries buffered → `out_valid` = 0 and `illegal_count` = 0 immediately, before the next clock edge; normal operation resumes after release.
